// File: rtl/df_load_rsp_pkg.sv
// rtl/df_load_rsp_pkg.sv - shared state type, load op codes and load-op decode for the DF load response
package df_load_rsp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } df_ld_state_t;

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;

   // Byte-enable polarity: a BE bit equal to BE_ON selects that lane.
   localparam logic       BE_ON         = 1'b1;
   localparam logic [4:0] REG_ZERO_ADDR = 5'd0;

   function automatic logic is_load_op(input logic [7:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP);
   endfunction

endpackage

// File: rtl/df_load_rsp_load_extend.sv
// rtl/df_load_rsp_load_extend.sv - lane select and sign/zero extension of a returned load word
module df_load_rsp_load_extend
   import df_load_rsp_pkg::*;
(
   input  logic [7:0]  alu_op,
   input  logic [3:0]  be,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [3:0]  sel;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        byte_ok;
   logic        half_ok;

   always_comb begin
      sel     = BE_ON ? be : ~be;
      byte_v  = '0;
      half_v  = '0;
      byte_ok = 1'b1;
      half_ok = 1'b1;
      result  = '0;

      case (sel)
         4'b0001: byte_v = rdata[7:0];
         4'b0010: byte_v = rdata[15:8];
         4'b0100: byte_v = rdata[23:16];
         4'b1000: byte_v = rdata[31:24];
         default: byte_ok = 1'b0;
      endcase

      case (sel)
         4'b0011: half_v = rdata[15:0];
         4'b1100: half_v = rdata[31:16];
         default: half_ok = 1'b0;
      endcase

      // An illegal lane pattern for the op yields zero data.
      case (alu_op)
         EXE_LB_OP:  if (byte_ok) result = {{24{byte_v[7]}}, byte_v};
         EXE_LBU_OP: if (byte_ok) result = {24'd0, byte_v};
         EXE_LH_OP:  if (half_ok) result = {{16{half_v[15]}}, half_v};
         EXE_LHU_OP: if (half_ok) result = {16'd0, half_v};
         EXE_LW_OP:  if (sel == 4'b1111) result = rdata;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/df_load_rsp.sv
// rtl/df_load_rsp.sv - DF-stage load response consumer: stall while waiting, extend, buffer under WB stall
module df_load_rsp
   import df_load_rsp_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STALL_WB,
   input  logic [7:0]  DF_ALU_OP,
   input  logic        DF_GPR_WE,
   input  logic [31:0] DF_GPR_WDATA,
   input  logic [4:0]  DF_GPR_WADDR,
   input  logic [3:0]  DF_SRAM_DATA_BE,
   input  logic [31:0] SRAM_RDATA,
   input  logic        SRAM_RVALID,
   output logic        STALL_REQ,
   output logic        WB_GPR_WE,
   output logic [31:0] WB_GPR_WDATA,
   output logic [4:0]  WB_GPR_WADDR,
   output logic        LOAD_TIMEOUT
);

   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   df_ld_state_t     state_q, state_d;
   logic             wb_we_q, wb_we_d;
   logic [31:0]      wb_wdata_q, wb_wdata_d;
   logic [4:0]       wb_waddr_q, wb_waddr_d;
   logic             buf_we_q, buf_we_d;
   logic [31:0]      buf_wdata_q, buf_wdata_d;
   logic [4:0]       buf_waddr_q, buf_waddr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             is_ld;
   logic [31:0]      ext_data;

   df_load_rsp_load_extend u_load_extend (
      .alu_op (DF_ALU_OP),
      .be     (DF_SRAM_DATA_BE),
      .rdata  (SRAM_RDATA),
      .result (ext_data)
   );

   always_comb begin
      state_d     = state_q;
      wb_we_d     = wb_we_q;
      wb_wdata_d  = wb_wdata_q;
      wb_waddr_d  = wb_waddr_q;
      buf_we_d    = buf_we_q;
      buf_wdata_d = buf_wdata_q;
      buf_waddr_d = buf_waddr_q;
      cnt_d       = '0;
      timeout_d   = timeout_q;
      STALL_REQ   = 1'b0;
      is_ld       = is_load_op(DF_ALU_OP);

      case (state_q)
         IDLE: begin
            if (is_ld && SRAM_RVALID) begin
               if (STALL_WB) begin
                  buf_we_d    = DF_GPR_WE;
                  buf_wdata_d = ext_data;
                  buf_waddr_d = DF_GPR_WADDR;
                  state_d     = HOLD;
                  STALL_REQ   = 1'b1;
               end else begin
                  wb_we_d    = DF_GPR_WE;
                  wb_wdata_d = ext_data;
                  wb_waddr_d = DF_GPR_WADDR;
               end
            end else if (is_ld) begin
               STALL_REQ = 1'b1;
               state_d   = WAIT;
               if (!STALL_WB) begin
                  wb_we_d    = 1'b0;
                  wb_wdata_d = '0;
                  wb_waddr_d = REG_ZERO_ADDR;
               end
            end else if (!STALL_WB) begin
               wb_we_d    = DF_GPR_WE;
               wb_wdata_d = DF_GPR_WDATA;
               wb_waddr_d = DF_GPR_WADDR;
            end
         end
         WAIT: begin
            // EX/DF is frozen while we wait, so DF_* still describe this load.
            if (SRAM_RVALID && STALL_WB) begin
               buf_we_d    = DF_GPR_WE;
               buf_wdata_d = ext_data;
               buf_waddr_d = DF_GPR_WADDR;
               state_d     = HOLD;
               STALL_REQ   = 1'b1;
            end else if (SRAM_RVALID) begin
               wb_we_d    = DF_GPR_WE;
               wb_wdata_d = ext_data;
               wb_waddr_d = DF_GPR_WADDR;
               state_d    = IDLE;
            end else begin
               STALL_REQ = 1'b1;
               cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               if (TIMEOUT_CYC != 0 && cnt_d == CNT_MAX) timeout_d = 1'b1;
               if (!STALL_WB) begin
                  wb_we_d    = 1'b0;
                  wb_wdata_d = '0;
                  wb_waddr_d = REG_ZERO_ADDR;
               end
            end
         end
         HOLD: begin
            if (STALL_WB) begin
               STALL_REQ = 1'b1;
            end else begin
               wb_we_d    = buf_we_q;
               wb_wdata_d = buf_wdata_q;
               wb_waddr_d = buf_waddr_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         wb_we_q     <= 1'b0;
         wb_wdata_q  <= '0;
         wb_waddr_q  <= REG_ZERO_ADDR;
         buf_we_q    <= 1'b0;
         buf_wdata_q <= '0;
         buf_waddr_q <= REG_ZERO_ADDR;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wb_we_q     <= wb_we_d;
         wb_wdata_q  <= wb_wdata_d;
         wb_waddr_q  <= wb_waddr_d;
         buf_we_q    <= buf_we_d;
         buf_wdata_q <= buf_wdata_d;
         buf_waddr_q <= buf_waddr_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign WB_GPR_WE    = wb_we_q;
   assign WB_GPR_WDATA = wb_wdata_q;
   assign WB_GPR_WADDR = wb_waddr_q;
   assign LOAD_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_df_load_rsp.sv
// tb/tb_df_load_rsp.sv - directed self-checking bench for df_load_rsp (watchdog set to 4 cycles)
module tb_df_load_rsp;
   import df_load_rsp_pkg::*;

   localparam logic [7:0] ADDU_OP = 8'b0010_0001;

   logic        CLK = 1'b0;
   logic        RST;
   logic        STALL_WB;
   logic [7:0]  DF_ALU_OP;
   logic        DF_GPR_WE;
   logic [31:0] DF_GPR_WDATA;
   logic [4:0]  DF_GPR_WADDR;
   logic [3:0]  DF_SRAM_DATA_BE;
   logic [31:0] SRAM_RDATA;
   logic        SRAM_RVALID;
   logic        STALL_REQ;
   logic        WB_GPR_WE;
   logic [31:0] WB_GPR_WDATA;
   logic [4:0]  WB_GPR_WADDR;
   logic        LOAD_TIMEOUT;

   int n_cmp = 0;
   int n_err = 0;

   df_load_rsp #(.TIMEOUT_CYC(4)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .STALL_WB        (STALL_WB),
      .DF_ALU_OP       (DF_ALU_OP),
      .DF_GPR_WE       (DF_GPR_WE),
      .DF_GPR_WDATA    (DF_GPR_WDATA),
      .DF_GPR_WADDR    (DF_GPR_WADDR),
      .DF_SRAM_DATA_BE (DF_SRAM_DATA_BE),
      .SRAM_RDATA      (SRAM_RDATA),
      .SRAM_RVALID     (SRAM_RVALID),
      .STALL_REQ       (STALL_REQ),
      .WB_GPR_WE       (WB_GPR_WE),
      .WB_GPR_WDATA    (WB_GPR_WDATA),
      .WB_GPR_WADDR    (WB_GPR_WADDR),
      .LOAD_TIMEOUT    (LOAD_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata);
      chk({tag, "_we"}, 32'(WB_GPR_WE), 32'(we));
      chk({tag, "_waddr"}, 32'(WB_GPR_WADDR), 32'(waddr));
      chk({tag, "_wdata"}, WB_GPR_WDATA, wdata);
   endtask

   task automatic drive(input logic [7:0] op, input logic we, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] rdata, input logic rvalid);
      DF_ALU_OP       = op;
      DF_GPR_WE       = we;
      DF_GPR_WADDR    = waddr;
      DF_GPR_WDATA    = wdata;
      DF_SRAM_DATA_BE = be;
      SRAM_RDATA      = rdata;
      SRAM_RVALID     = rvalid;
   endtask

   initial begin
      RST      = 1'b1;
      STALL_WB = 1'b0;
      drive(EXE_LW_OP, 1'b1, 5'd7, 32'h0, 4'b1111, 32'hFFFF_FFFF, 1'b1);
      tick();
      tick();
      chk_wb("reset", 1'b0, 5'd0, 32'h0);
      chk("reset_stall", 32'(STALL_REQ), 32'd0);
      chk("reset_timeout", 32'(LOAD_TIMEOUT), 32'd0);

      // non-load pass-through
      RST = 1'b0;
      drive(ADDU_OP, 1'b1, 5'd5, 32'h1234, 4'b0000, 32'h0, 1'b0);
      #1 chk("addu_stall", 32'(STALL_REQ), 32'd0);
      tick();
      chk_wb("addu", 1'b1, 5'd5, 32'h1234);
      chk("addu_stall2", 32'(STALL_REQ), 32'd0);

      // same-cycle byte loads
      drive(EXE_LB_OP, 1'b1, 5'd6, 32'h0, 4'b0100, 32'h00F0_0000, 1'b1);
      #1 chk("lb_stall", 32'(STALL_REQ), 32'd0);
      tick();
      chk_wb("lb", 1'b1, 5'd6, 32'hFFFF_FFF0);
      drive(EXE_LBU_OP, 1'b1, 5'd6, 32'h0, 4'b0100, 32'h00F0_0000, 1'b1);
      tick();
      chk_wb("lbu", 1'b1, 5'd6, 32'h0000_00F0);

      // low-half unsigned and an illegal word lane pattern
      drive(EXE_LHU_OP, 1'b1, 5'd8, 32'h0, 4'b0011, 32'h1234_8001, 1'b1);
      tick();
      chk_wb("lhu", 1'b1, 5'd8, 32'h0000_8001);
      drive(EXE_LW_OP, 1'b1, 5'd10, 32'h0, 4'b0011, 32'h1234_8001, 1'b1);
      tick();
      chk_wb("lw_badbe", 1'b1, 5'd10, 32'h0);

      // delayed half load: three stall cycles with bubbles
      drive(EXE_LH_OP, 1'b1, 5'd9, 32'h0, 4'b1100, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("lh_stall%0d", i), 32'(STALL_REQ), 32'd1);
         tick();
         chk_wb($sformatf("lh_bubble%0d", i), 1'b0, 5'd0, 32'h0);
      end
      SRAM_RVALID = 1'b1;
      SRAM_RDATA  = 32'h8001_1234;
      #1 chk("lh_rsp_stall", 32'(STALL_REQ), 32'd0);
      tick();
      chk_wb("lh", 1'b1, 5'd9, 32'hFFFF_8001);
      drive(ADDU_OP, 1'b1, 5'd5, 32'h55, 4'b0000, 32'h0, 1'b0);
      #1 chk("lh_after_stall", 32'(STALL_REQ), 32'd0);
      tick();
      chk_wb("addu2", 1'b1, 5'd5, 32'h55);

      // response arrives while WB is stalled
      STALL_WB = 1'b1;
      drive(EXE_LW_OP, 1'b1, 5'd3, 32'h0, 4'b1111, 32'hCAFE_BABE, 1'b1);
      #1 chk("hold_stall0", 32'(STALL_REQ), 32'd1);
      tick();
      chk_wb("hold0", 1'b1, 5'd5, 32'h55);
      SRAM_RDATA = 32'hDEAD_BEEF;
      #1 chk("hold_stall1", 32'(STALL_REQ), 32'd1);
      tick();
      chk_wb("hold1", 1'b1, 5'd5, 32'h55);
      SRAM_RVALID = 1'b0;
      STALL_WB    = 1'b0;
      #1 chk("hold_release_stall", 32'(STALL_REQ), 32'd0);
      tick();
      chk_wb("hold_out", 1'b1, 5'd3, 32'hCAFE_BABE);
      drive(ADDU_OP, 1'b0, 5'd0, 32'h0, 4'b0000, 32'h0, 1'b0);
      tick();

      // watchdog: response withheld for six cycles
      drive(EXE_LW_OP, 1'b1, 5'd4, 32'h0, 4'b1111, 32'h0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("wd_flag%0d", i), 32'(LOAD_TIMEOUT), (i >= 5) ? 32'd1 : 32'd0);
         chk($sformatf("wd_stall%0d", i), 32'(STALL_REQ), 32'd1);
      end
      SRAM_RVALID = 1'b1;
      SRAM_RDATA  = 32'h1122_3344;
      tick();
      chk_wb("wd_rsp", 1'b1, 5'd4, 32'h1122_3344);
      chk("wd_sticky", 32'(LOAD_TIMEOUT), 32'd1);

      // reset in the middle of a wait clears everything
      drive(EXE_LW_OP, 1'b1, 5'd4, 32'h0, 4'b1111, 32'h0, 1'b0);
      tick();
      tick();
      chk("mid_wait_stall", 32'(STALL_REQ), 32'd1);
      RST = 1'b1;
      drive(ADDU_OP, 1'b1, 5'd5, 32'h77, 4'b0000, 32'h0, 1'b0);
      tick();
      RST = 1'b0;
      chk_wb("rst2", 1'b0, 5'd0, 32'h0);
      chk("rst2_timeout", 32'(LOAD_TIMEOUT), 32'd0);
      #1 chk("rst2_stall", 32'(STALL_REQ), 32'd0);
      tick();
      chk_wb("post_rst_addu", 1'b1, 5'd5, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
